// File: rtl/dii_packet_fifo.sv
// DII flit FIFO with circular storage, optional store-and-forward, flush and status; first-word fall-through, 1-cycle latency.
// Backpressure: flit_in_ready drops only at full and never looks at flit_out_ready.
package dii_package;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;
endpackage

module dii_packet_fifo
  import dii_package::*;
#(
  parameter int DEPTH        = 8,
  parameter int FULLPACKET   = 0,
  parameter int AFULL_THRESH = DEPTH - 2,
  localparam int CW          = $clog2(DEPTH + 1),
  localparam int PW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  dii_flit       flit_in,
  output logic          flit_in_ready,
  output dii_flit       flit_out,
  input  logic          flit_out_ready,
  output logic [CW-1:0] fill_level,
  output logic [CW-1:0] packet_count,
  output logic          almost_full
);

  logic [16:0]   mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic          in_fire, out_fire;
  logic          out_valid;

  assign flit_in_ready = !rst && !flush && (cnt != CW'(DEPTH));
  assign in_fire       = flit_in.valid && flit_in_ready;
  assign out_fire      = out_valid && flit_out_ready;

  // The full fallback lets packets longer than DEPTH drain in store-and-forward mode.
  always_comb begin
    if (FULLPACKET != 0)
      out_valid = (packet_count != '0) || (cnt == CW'(DEPTH));
    else
      out_valid = (cnt != '0);
    if (rst || flush)
      out_valid = 1'b0;
  end

  assign flit_out.valid = out_valid;
  assign flit_out.last  = mem[rp][16];
  assign flit_out.data  = mem[rp][15:0];
  assign fill_level     = cnt;
  assign almost_full    = (cnt >= CW'(AFULL_THRESH));

  always_ff @(posedge clk) begin
    if (in_fire)
      mem[wp] <= {flit_in.last, flit_in.data};
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp           <= '0;
      rp           <= '0;
      cnt          <= '0;
      packet_count <= '0;
    end else begin
      if (in_fire)
        wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
      if (out_fire)
        rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + 1'b1;
      case ({in_fire, out_fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      case ({in_fire && flit_in.last, out_fire && flit_out.last})
        2'b10:   packet_count <= packet_count + 1'b1;
        2'b01:   packet_count <= packet_count - 1'b1;
        default: packet_count <= packet_count;
      endcase
    end
  end

endmodule
